// File: rtl/leading_bits_scanner.sv
// Multi-cycle leading-run counter: walks a wide vector CHUNK bits per cycle through one leadingBits.
// Build option LEADING_BITS_SCANNER_EARLY_EXIT_EN: stop at the first chunk that ends the run (else constant latency).

module leadingBits #(
   parameter int   WIDTH = 8,
   parameter logic BIT   = 1'b1
) (
   input  logic [0:WIDTH-1]              vec_i,
   output logic [$clog2(WIDTH+1)-1:0]    count_o
);
   localparam int CW = $clog2(WIDTH + 1);

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (vec_i[i] != BIT) break;
         count_o = CW'(i + 1);
      end
   end
endmodule

module leading_bits_scanner #(
   parameter int   WIDTH = 64,
   parameter int   CHUNK = 8,
   parameter logic BIT   = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [0:WIDTH-1]             in_vector,
   input  logic                         abort,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(WIDTH+1)-1:0]   out_count,
   output logic                         out_all,
   output logic                         busy
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(WIDTH + 1);
   localparam int LW     = $clog2(CHUNK + 1);
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q;
   logic [0:WIDTH-1] shift_q;
   logic [IW-1:0]    idx_q;
   logic [CW-1:0]    acc_q;
   logic [CW-1:0]    acc_d;
   logic             all_q;
   logic             valid_q;
   logic [LW-1:0]    lc;
   logic             lc_full;
   logic             last_chunk;
`ifndef LEADING_BITS_SCANNER_EARLY_EXIT_EN
   logic             stopped_q;
`endif

   leadingBits #(.WIDTH(CHUNK), .BIT(BIT)) u_lead (
      .vec_i   (shift_q[0:CHUNK-1]),
      .count_o (lc)
   );

   assign lc_full    = (lc == LW'(CHUNK));
   assign last_chunk = (idx_q == IW'(NCHUNK - 1));

   always_comb begin
      acc_d = acc_q + CW'(lc);
`ifndef LEADING_BITS_SCANNER_EARLY_EXIT_EN
      // Once the run has ended, the remaining chunks only pad out the fixed latency.
      if (stopped_q) acc_d = acc_q;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         all_q     <= 1'b0;
         valid_q   <= 1'b0;
`ifndef LEADING_BITS_SCANNER_EARLY_EXIT_EN
         stopped_q <= 1'b0;
`endif
      end else if (abort) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         all_q     <= 1'b0;
         valid_q   <= 1'b0;
`ifndef LEADING_BITS_SCANNER_EARLY_EXIT_EN
         stopped_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  shift_q   <= in_vector;
                  idx_q     <= '0;
                  acc_q     <= '0;
                  all_q     <= 1'b0;
                  state_q   <= SCAN;
`ifndef LEADING_BITS_SCANNER_EARLY_EXIT_EN
                  stopped_q <= 1'b0;
`endif
               end
            end
            SCAN: begin
               acc_q   <= acc_d;
               shift_q <= shift_q << CHUNK;
               idx_q   <= idx_q + 1'b1;
`ifdef LEADING_BITS_SCANNER_EARLY_EXIT_EN
               if (!lc_full || last_chunk) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
                  all_q   <= lc_full;
               end
`else
               if (!lc_full) stopped_q <= 1'b1;
               if (last_chunk) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
                  all_q   <= (acc_d == CW'(WIDTH));
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = valid_q;
   assign out_count = acc_q;
   assign out_all   = all_q;
endmodule

// File: tb/tb_leading_bits_scanner.sv
// Scoreboard bench for leading_bits_scanner: driver queues expectations, negedge monitor checks results.

module tb_leading_bits_scanner;
   localparam int W  = 64;
   localparam int C  = 8;
   localparam int NC = W / C;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [0:W-1]  in_vector = '0;
   logic          abort = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_count;
   logic          out_all;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_edge = -1;

   typedef struct {
      int cnt;
      int all;
      int t;
      int lat;
      int bp;
   } exp_t;
   exp_t sb[$];

   leading_bits_scanner #(.WIDTH(W), .CHUNK(C), .BIT(1'b1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vector (in_vector),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_all   (out_all),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ref_count(input logic [0:W-1] v);
      int n = 0;
      while (n < W && v[n] == 1'b1) n++;
      return n;
   endfunction

   function automatic int ref_lat(input int n);
`ifdef LEADING_BITS_SCANNER_EARLY_EXIT_EN
      int j = n / C;
      if (j > NC - 1) j = NC - 1;
      return j + 1;
`else
      return NC + 0 * n;
`endif
   endfunction

   // Monitor: pops on the first cycle of each result, then checks it stays frozen under backpressure.
   int   cur_bp = 0;
   int   hold = 0;
   bit   in_done = 0;
   bit   prev_ready = 0;
   int   cap_cnt = 0;
   int   cap_all = 0;
   exp_t e;

   always @(negedge clk) begin
      if (!reset_n) begin
         in_done = 0;
         out_ready = 1'b0;
         prev_ready = 0;
      end else if (out_valid) begin
         if (!in_done) begin
            in_done = 1;
            hold = 0;
            if (sb.size() == 0) begin
               chk("unexpected_output", 1, 0);
               cur_bp = 0;
            end else begin
               e = sb.pop_front();
               cur_bp = e.bp;
               chk("count", int'(out_count), e.cnt);
               chk("all", int'(out_all), e.all);
               chk("latency", cyc - e.t, e.lat);
            end
            cap_cnt = int'(out_count);
            cap_all = int'(out_all);
         end else begin
            chk("hold_count", int'(out_count), cap_cnt);
            chk("hold_all", int'(out_all), cap_all);
         end
         chk("in_ready_in_done", int'(in_ready), 0);
         chk("busy_in_done", int'(busy), 1);
         if (hold >= cur_bp) begin
            out_ready = 1'b1;
            hs_edge = cyc + 1;
         end else begin
            out_ready = 1'b0;
            hold++;
         end
         prev_ready = out_ready;
      end else begin
         if (in_done && !prev_ready) chk("valid_dropped_early", 1, 0);
         in_done = 0;
         out_ready = 1'b0;
         prev_ready = 0;
      end
   end

   // Offers a vector, waits (bounded) for acceptance, optionally queues the expected result.
   task automatic send(input logic [0:W-1] v, input bit push, input int bp, output int t);
      int k = 0;
      exp_t x;
      t = -1;
      @(negedge clk);
      in_vector = v;
      in_valid = 1'b1;
      while (!in_ready) begin
         @(negedge clk);
         k++;
         if (k > 300) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      t = cyc + 1;
      if (push) begin
         x.cnt = ref_count(v);
         x.all = (x.cnt == W) ? 1 : 0;
         x.t   = t;
         x.lat = ref_lat(x.cnt);
         x.bp  = bp;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_vector = {$urandom, $urandom};
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || out_valid || busy) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("drain_done", (sb.size() == 0 && !busy) ? 1 : 0, 1);
   endtask

   function automatic logic [0:W-1] run_vec(input int len);
      logic [0:W-1] v;
      v = {$urandom, $urandom};
      for (int i = 0; i < len; i++) v[i] = 1'b1;
      if (len < W) v[len] = 1'b0;
      return v;
   endfunction

   int t_a;
   int t_b;
   logic [0:W-1] ones;
   logic [0:W-1] v;
   int lens[8] = '{0, 1, 7, 8, 9, 56, 63, 64};

   initial begin
      ones = '1;
      #3;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_count", int'(out_count), 0);
      chk("rst_out_all", int'(out_all), 0);
      chk("rst_busy", int'(busy), 0);
      #20 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);

      send(ones, 1, 0, t_a);
      v = ones; v[0] = 1'b0;
      send(v, 1, 0, t_a);
      send(run_vec(19), 1, 0, t_a);
      foreach (lens[i]) send(run_vec(lens[i]), 1, $urandom_range(0, 2), t_a);
      drain();

      // Backpressure, then the next job must be taken exactly one edge after the handshake.
      send(run_vec(37), 1, 5, t_a);
      send(run_vec(12), 1, 0, t_b);
      chk("accept_after_hs", t_b, hs_edge + 1);
      drain();

      // abort in the second SCAN cycle
      send(ones, 0, 0, t_a);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_out_count", int'(out_count), 0);
      repeat (12) @(negedge clk);
      send({8{8'h0F}}, 1, 0, t_a);
      drain();

      // abort wins over a simultaneous input offer
      @(negedge clk);
      in_vector = ones;
      in_valid = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      abort = 1'b0;
      chk("abort_blocks_accept", int'(busy), 0);

      // reset mid-SCAN
      send(ones, 0, 0, t_a);
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_count", int'(out_count), 0);
      chk("mid_rst_out_all", int'(out_all), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);
      send(ones, 1, 0, t_a);
      drain();

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0) v = {$urandom, $urandom};
         else v = run_vec($urandom_range(0, W));
         send(v, 1, $urandom_range(0, 3), t_a);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/leading_bits_scanner.md
Name: leading_bits_scanner

Overview:
- Multi-cycle leading-run counter for wide vectors; scans CHUNK bits per cycle through one CHUNK-wide leadingBits instance instead of a full-width combinational tree.
- Sequences the shared leadingBits datapath with an FSM and accumulator.
- Valid/ready on input and output; used wherever full-width leading-count timing is too slow, such as normaliser front-ends and free-slot search.

Parameters:
- WIDTH, 64, input vector width; must be a multiple of CHUNK.
- CHUNK, 8, bits examined per cycle; width of the internal leadingBits instance; >= 2.
- BIT, 1'b1, bit value whose leading run is counted; passed to leadingBits.
- Derived localparams: NCHUNK = WIDTH/CHUNK; CW = $clog2(WIDTH+1).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_vector valid.
- in_ready  out  1  scanner can accept; high only in IDLE.
- in_vector  in  [0:WIDTH-1]  vector to scan; index 0 is the leading bit.
- abort  in  1  synchronous cancel of any operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_count  out  CW  length of leading run of BIT, 0..WIDTH.
- out_all  out  1  every bit equals BIT (out_count == WIDTH).
- busy  out  1  high in SCAN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; out_valid = 0; out_count = 0; out_all = 0; busy = 0.
  - Shift register and chunk index cleared; in_ready = 1 once reset_n is high.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T: latch in_vector into the shift register, accumulator = 0, chunk index = 0, go to SCAN.
- SCAN, one chunk per cycle:
  - leadingBits sees shift register bits [0:CHUNK-1] and returns lc.
  - If lc < CHUNK, the run has ended: accumulator += lc, go to DONE.
  - If lc == CHUNK: accumulator += CHUNK and the shift register shifts toward index 0 by CHUNK.
    - If chunk index == NCHUNK-1, go to DONE with out_all = 1.
    - Otherwise increment chunk index.
  - The accumulator is CW bits wide and never overflows (maximum is WIDTH).
- DONE:
  - out_valid = 1; out_count and out_all held stable while out_ready = 0.
  - On out_ready: out_valid falls, go to IDLE.
  - in_ready stays 0, so there is no overlap between jobs.
- Latency (early-exit build): out_valid is high in the cycle after edge T+j+1, where j is the index of the chunk that ends the run (j = NCHUNK-1 for all-BIT). Minimum latency 1 cycle, maximum NCHUNK.
- abort:
  - From any state, at the next edge: go to IDLE, out_valid = 0, out_count = 0, out_all = 0, any in-progress result discarded.
  - abort has priority over in_valid and out_ready in the same cycle, so an input offered together with abort is not accepted.
- Simultaneous out_ready and in_valid in DONE: result handshake completes; the input is taken in the following IDLE cycle, never in the same cycle.
- in_vector is ignored outside IDLE; changing it mid-scan has no effect.
- Reset mid-operation returns to reset values immediately; no output is produced.

Optional Feature:
- Macro: LEADING_BITS_SCANNER_EARLY_EXIT_EN.
- Defined: SCAN ends on the first chunk with lc < CHUNK, giving the variable latency above.
- Undefined: constant latency. SCAN always processes all NCHUNK chunks.
  - A sticky "stopped" flag is set on the first lc < CHUNK.
  - Chunks after the flag is set add nothing to the accumulator.
  - DONE is entered after exactly NCHUNK SCAN cycles; out_valid is high after edge T+NCHUNK.
- Results are identical in both builds.

Test Plan (WIDTH=64, CHUNK=8, BIT=1):
- in_vector all ones -> out_count = 64, out_all = 1, out_valid 8 cycles after accept in both builds.
- in_vector[0] = 0, rest ones -> out_count = 0, out_all = 0; latency 1 cycle with EARLY_EXIT_EN, 8 without.
- in_vector[0:18] ones, [19] = 0, rest random -> out_count = 19; latency 3 with EARLY_EXIT_EN, 8 without.
- Backpressure: out_ready low for 5 cycles after out_valid, then high -> out_count and out_all stable, in_ready = 0 throughout; next vector accepted the cycle after the handshake and scanned correctly.
- abort asserted in the 2nd SCAN cycle of an all-ones vector -> out_valid never rises, IDLE next cycle; a following 0x0F..-pattern vector gives its correct count (0 for leading zero).
- reset_n pulsed low mid-SCAN -> all outputs at reset values asynchronously; in_ready = 1 after release; a subsequent all-ones vector returns 64.
